// File: rtl/prog_timer_ctrl.sv
// prog_timer_ctrl: period/one-shot controller for an external NIB-stage
// 4-bit counter chain. It computes the preload word and drives ld/en/clr.
//
// Ports:
//   cp, mr_b            clock and async active-low reset
//   cfg_valid/ready     period handshake (cfg_period, cfg_oneshot)
//   start, stop         run control
//   chain_tc            terminal count returned by the last stage
//   p, ld, en, clr      chain preload word and control
//   tick, busy          registered tick pulse and run status
//   tick_cnt            saturating tick count since the last LOAD
module prog_timer_ctrl #(
  parameter  int NIB = 2,
  localparam int W   = 4 * NIB
) (
  input  logic         cp,
  input  logic         mr_b,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [W-1:0] cfg_period,
  input  logic         cfg_oneshot,
  input  logic         start,
  input  logic         stop,
  input  logic         chain_tc,
  output logic [W-1:0] p,
  output logic         ld,
  output logic         en,
  output logic         clr,
  output logic         tick,
  output logic         busy,
  output logic [7:0]   tick_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } state_e;

  state_e       state_q;
  logic         loaded_q;
  logic         oneshot_q;
  logic         first_q;
  logic [W-1:0] p_q;
  logic         tick_q;
  logic [7:0]   tick_cnt_q;

  logic in_idle;
  logic in_load;
  logic in_run;
  logic in_halt;
  logic cfg_acc;
  logic go;
  logic tc_hit;

  assign in_idle = (state_q == IDLE);
  assign in_load = (state_q == LOAD);
  assign in_run  = (state_q == RUN);
  assign in_halt = (state_q == HALT);

  assign cfg_ready = in_idle | in_halt;
  assign busy      = in_load | in_run;

  // A config handshake wins over start in the same cycle.
  assign cfg_acc = cfg_valid & cfg_ready;
  assign go      = start & loaded_q & ~cfg_acc;

  // Terminal count only matters while running, and stop overrides it.
  assign tc_hit = in_run & chain_tc & ~stop;

  // Periodic mode reloads in the tc cycle itself, so the chain
  // restarts from p with no dead cycle and the period is exactly N.
  always_comb begin
    ld  = 1'b0;
    en  = 1'b0;
    clr = 1'b0;
    unique case (1'b1)
      in_load: ld = 1'b1;
      in_run: begin
        en = ~stop;
        ld = tc_hit & ~oneshot_q;
      end
      in_halt: clr = first_q;
      default: ;
    endcase
  end

  always_ff @(posedge cp or negedge mr_b) begin
    if (!mr_b) begin
      state_q    <= IDLE;
      loaded_q   <= 1'b0;
      oneshot_q  <= 1'b0;
      first_q    <= 1'b0;
      p_q        <= '0;
      tick_q     <= 1'b0;
      tick_cnt_q <= '0;
    end else begin
      tick_q  <= 1'b0;
      first_q <= 1'b0;
      unique case (state_q)
        IDLE, HALT: begin
          if (cfg_acc) begin
            loaded_q  <= 1'b1;
            oneshot_q <= cfg_oneshot;
            // Two's complement gives 2^W - N; N = 0 maps to 0,
            // which is a full 2^W-cycle period.
            p_q       <= ~cfg_period + 1'b1;
          end else if (go) begin
            state_q <= LOAD;
          end
        end
        LOAD: begin
          tick_cnt_q <= '0;
          if (stop) begin
            state_q <= HALT;
            first_q <= 1'b1;
          end else begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (stop) begin
            state_q <= HALT;
            first_q <= 1'b1;
          end else if (chain_tc) begin
            tick_q <= 1'b1;
            if (tick_cnt_q != 8'hFF) begin
              tick_cnt_q <= tick_cnt_q + 8'd1;
            end
            if (oneshot_q) begin
              state_q <= HALT;
              first_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign p        = p_q;
  assign tick     = tick_q;
  assign tick_cnt = tick_cnt_q;

endmodule

// File: tb/tb_prog_timer_ctrl.sv
// tb_prog_timer_ctrl: bench for prog_timer_ctrl with a behavioural
// counter chain and an arithmetic tick-schedule reference model.
module tb_prog_timer_ctrl;

  localparam int NIB = 2;
  localparam int W   = 4 * NIB;
  localparam int M   = 1 << W;

  logic         cp = 1'b0;
  logic         mr_b;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [W-1:0] cfg_period;
  logic         cfg_oneshot;
  logic         start;
  logic         stop;
  logic         chain_tc;
  logic [W-1:0] p;
  logic         ld;
  logic         en;
  logic         clr;
  logic         tick;
  logic         busy;
  logic [7:0]   tick_cnt;

  logic [W-1:0] chain = '0;
  logic         tc_inj = 1'b0;

  always #5 cp = ~cp;

  prog_timer_ctrl #(.NIB(NIB)) dut (
    .cp         (cp),
    .mr_b       (mr_b),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_period (cfg_period),
    .cfg_oneshot(cfg_oneshot),
    .start      (start),
    .stop       (stop),
    .chain_tc   (chain_tc),
    .p          (p),
    .ld         (ld),
    .en         (en),
    .clr        (clr),
    .tick       (tick),
    .busy       (busy),
    .tick_cnt   (tick_cnt)
  );

  // NIB-stage chain, cet tied to en; clear beats load beats count.
  always @(posedge cp) begin
    if (clr)     chain <= '0;
    else if (ld) chain <= p;
    else if (en) chain <= chain + 1'b1;
  end
  assign chain_tc = (en && chain == '1) || tc_inj;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: mode 0 idle, 1 load, 2 run, 3 halt.
  int m_mode, m_n, m_t0, m_cnt, m_p;
  bit m_loaded, m_one, m_first, m_tick;
  int t = 0;

  bit h_tick[int];
  bit h_clr[int];
  bit h_ld[int];
  bit h_en[int];
  bit h_busy[int];
  bit h_rdy[int];
  int h_cnt[int];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, t);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_n = 0; m_t0 = 0; m_cnt = 0; m_p = 0;
    m_loaded = 0; m_one = 0; m_first = 0; m_tick = 0;
  endtask

  // Called at posedge+1; leaves at posedge+1 with reset released.
  task automatic do_reset();
    cfg_valid = 0; start = 0; stop = 0; tc_inj = 0;
    cfg_period = '0; cfg_oneshot = 0;
    mr_b = 1'b0;
    #1;
    chk("rst_ld", 32'(ld), 0);
    chk("rst_en", 32'(en), 0);
    chk("rst_clr", 32'(clr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_ready", 32'(cfg_ready), 1);
    chk("rst_p", 32'(p), 0);
    chk("rst_cnt", 32'(tick_cnt), 0);
    @(posedge cp); #1;
    mr_b = 1'b1;
    model_reset();
  endtask

  task automatic step(input bit v, input int per, input bit one,
                      input bit st, input bit sp, input bit inj);
    int el;
    int pw;
    bit e_tc, e_ld, e_en, e_clr, e_rdy, e_busy, nt;
    cfg_valid = v;
    cfg_period = per[W-1:0];
    cfg_oneshot = one;
    start = st;
    stop = sp;
    tc_inj = inj;
    @(negedge cp);
    h_tick[t] = tick; h_clr[t] = clr; h_ld[t] = ld;
    h_en[t] = en; h_busy[t] = busy; h_rdy[t] = cfg_ready;
    h_cnt[t] = int'(tick_cnt);
    el = t - m_t0;
    e_tc = (m_mode == 2) && (m_n > 0) && (el >= m_n) &&
           ((el % m_n) == 0) && !sp;
    e_rdy = (m_mode == 0) || (m_mode == 3);
    e_busy = (m_mode == 1) || (m_mode == 2);
    e_clr = (m_mode == 3) && m_first;
    e_en = (m_mode == 2) && !sp;
    e_ld = (m_mode == 1) || (e_tc && !m_one);
    chk("ready", 32'(cfg_ready), 32'(e_rdy));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("ld", 32'(ld), 32'(e_ld));
    chk("en", 32'(en), 32'(e_en));
    chk("clr", 32'(clr), 32'(e_clr));
    chk("tick", 32'(tick), 32'(m_tick));
    chk("tick_cnt", 32'(tick_cnt), 32'(m_cnt));
    chk("p", 32'(p), 32'(m_p));
    if (m_mode == 2)
      chk("chain_tc", 32'(chain_tc), 32'(e_tc || inj));
    nt = 0;
    m_first = 0;
    case (m_mode)
      0, 3: begin
        if (v) begin
          pw = per & (M - 1);
          m_loaded = 1;
          m_n = (pw == 0) ? M : pw;
          m_one = one;
          m_p = (M - m_n) % M;
        end else if (st && m_loaded) begin
          m_mode = 1;
        end
      end
      1: begin
        m_cnt = 0;
        m_t0 = t;
        if (sp) begin m_mode = 3; m_first = 1; end
        else m_mode = 2;
      end
      default: begin
        if (sp) begin
          m_mode = 3; m_first = 1;
        end else if (e_tc) begin
          nt = 1;
          if (m_cnt < 255) m_cnt++;
          if (m_one) begin m_mode = 3; m_first = 1; end
        end
      end
    endcase
    m_tick = nt;
    t++;
    @(posedge cp); #1;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    logic [W-1:0] n;
    logic [W-1:0] exp_p;
  } vec_t;

  vec_t vt[8];

  initial begin
    int tl;
    int cnt;
    mr_b = 1'b0;
    cfg_valid = 0; start = 0; stop = 0;
    cfg_period = '0; cfg_oneshot = 0;
    model_reset();
    vt[0] = '{8'd0,   8'h00};
    vt[1] = '{8'd1,   8'hFF};
    vt[2] = '{8'd5,   8'hFB};
    vt[3] = '{8'd3,   8'hFD};
    vt[4] = '{8'd2,   8'hFE};
    vt[5] = '{8'd128, 8'h80};
    vt[6] = '{8'd255, 8'h01};
    vt[7] = '{8'd100, 8'h9C};
    @(posedge cp); #1;
    do_reset();

    // Preload word table.
    for (int i = 0; i < 8; i++) begin
      step(1, int'(vt[i].n), 0, 0, 0, 0);
      chk("tbl_p", 32'(p), 32'(vt[i].exp_p));
      chk("tbl_ready", 32'(cfg_ready), 1);
    end

    // N=5 periodic.
    do_reset();
    step(1, 5, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    tl = t;
    idle_n(18);
    chk("t1_p", 32'(p), 32'hFB);
    chk("t1_ld_t0", 32'(h_ld[tl]), 1);
    chk("t1_tick5", 32'(h_tick[tl+5]), 0);
    chk("t1_tick6", 32'(h_tick[tl+6]), 1);
    chk("t1_tick11", 32'(h_tick[tl+11]), 1);
    chk("t1_tick16", 32'(h_tick[tl+16]), 1);
    chk("t1_cnt3", 32'(h_cnt[tl+16]), 3);

    // N=3 one-shot.
    do_reset();
    step(1, 3, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    tl = t;
    idle_n(12);
    chk("t2_tick4", 32'(h_tick[tl+4]), 1);
    chk("t2_clr4", 32'(h_clr[tl+4]), 1);
    chk("t2_busy4", 32'(h_busy[tl+4]), 0);
    chk("t2_rdy4", 32'(h_rdy[tl+4]), 1);
    chk("t2_clr5", 32'(h_clr[tl+5]), 0);
    cnt = 0;
    for (int i = tl + 5; i < tl + 12; i++) cnt += int'(h_tick[i]);
    chk("t2_noextra", 32'(cnt), 0);

    // N=1 periodic, then N=0 periodic.
    do_reset();
    step(1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    tl = t;
    idle_n(10);
    chk("t3_tick1", 32'(h_tick[tl+1]), 0);
    for (int i = 2; i < 10; i++)
      chk("t3_every", 32'(h_tick[tl+i]), 1);
    step(0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    tl = t;
    idle_n(520);
    chk("t3_p0", 32'(p), 0);
    chk("t3_t256", 32'(h_tick[tl+256]), 0);
    chk("t3_t257", 32'(h_tick[tl+257]), 1);
    chk("t3_t512", 32'(h_tick[tl+512]), 0);
    chk("t3_t513", 32'(h_tick[tl+513]), 1);

    // Stop on the terminal-count cycle.
    do_reset();
    step(1, 4, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    tl = t;
    idle_n(4);
    step(0, 0, 0, 0, 1, 1);
    idle_n(3);
    chk("t4_ld", 32'(h_ld[tl+4]), 0);
    chk("t4_en", 32'(h_en[tl+4]), 0);
    chk("t4_clr", 32'(h_clr[tl+5]), 1);
    chk("t4_tick", 32'(h_tick[tl+5]), 0);
    chk("t4_halt", 32'(h_rdy[tl+5]), 1);

    // Start without config; config and start together.
    do_reset();
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("t5_noload", 32'(h_ld[t-1]), 0);
    chk("t5_idle", 32'(busy), 0);
    step(1, 2, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("t5_cfg_nogo", 32'(h_busy[t-1]), 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("t5_go", 32'(h_ld[t-1]), 1);
    idle_n(6);

    // Reset in the middle of a run.
    do_reset();
    step(1, 7, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    idle_n(4);
    chk("t6_running", 32'(busy), 1);
    do_reset();
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("t6_needcfg", 32'(h_busy[t-1]), 0);
    step(1, 7, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("t6_rerun", 32'(h_busy[t-1]), 1);
    idle_n(10);

    // Randomised traffic.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      bit v, one, st, sp, inj;
      int per;
      if ($urandom_range(0, 699) == 0) begin
        do_reset();
      end else begin
        v = ($urandom_range(0, 7) == 0);
        per = ($urandom_range(0, 19) == 0) ? 0 :
              int'($urandom_range(1, 12));
        one = ($urandom_range(0, 2) == 0);
        st = ($urandom_range(0, 3) == 0);
        sp = ($urandom_range(0, 24) == 0);
        inj = sp && ($urandom_range(0, 1) == 0);
        step(v, per, one, st, sp, inj);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
